// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {FETCH, FLUSH} fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with clear; DEPTH must be a power of two >= 2.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = $bits(fetch_entry_t),
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited imem requests, in-order queue, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall saturating counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] count, outstanding, outstanding_next;
  logic [CntW:0]   credit_used;
  logic [31:0]     resp_pc;
  fetch_entry_t    head, resp_entry;
  logic            req_fire, resp_keep, pop;
  logic [1:0]      unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Credits come from registers only so the request never depends on imem_req_ready.
  assign credit_used    = (CntW + 1)'(count) + (CntW + 1)'(outstanding);
  assign imem_req_valid = ~reset & (state_q == FETCH) &
                          (credit_used < (CntW + 1)'(QUEUE_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign resp_keep  = imem_resp_valid & (state_q == FETCH) & ~redirect_valid;
  assign pop        = instr_valid & instr_ready & ~redirect_valid;
  assign resp_entry = '{pc: resp_pc, word: imem_resp_data};

  assign outstanding_next = outstanding + CntW'(req_fire) - CntW'(imem_resp_valid);

  // PCs of in-flight requests; its occupancy is the outstanding count.
  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (32)
  ) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (imem_resp_valid),
    .pop_data  (resp_pc),
    .count     (outstanding)
  );

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (resp_keep),
    .push_data (resp_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      pc_d = pc_q + 32'(INSTR_BYTES);
    end
    case (state_q)
      FETCH:   if (redirect_valid && outstanding_next != '0) state_d = FLUSH;
      FLUSH:   if (!redirect_valid && outstanding_next == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_valid = ~reset & (count != '0);
  assign instr       = instr_valid ? head.word : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop && perf_fetched_q != '1) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (state_q == FETCH && !instr_valid && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
